// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Round-robin writeback scheduler sharing the register-file write
//            port between ALU results and a 2-entry load-return FIFO, with a
//            dedicated stack-pointer path. Optional pending-write scoreboard
//            output enabled by macro WBARB_PENDING_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_arbiter #(
  parameter int                WIDTH  = 32,
  parameter int                COUNTP = 4,
  parameter logic [COUNTP-1:0] SPREG  = 4'd15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [COUNTP-1:0] alu_addr,
  input  logic [WIDTH-1:0]  alu_data,
  input  logic [1:0]        alu_en,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [COUNTP-1:0] mem_addr,
  input  logic [WIDTH-1:0]  mem_data,
  input  logic [1:0]        mem_en,
  input  logic              sp_valid,
  input  logic [WIDTH-1:0]  sp_data_i,
  input  logic [1:0]        sp_en_i,
  output logic [COUNTP-1:0] write_addr,
  output logic [WIDTH-1:0]  write_data,
  output logic [1:0]        write_en,
  output logic [WIDTH-1:0]  sp_data_o,
  output logic [1:0]        sp_en
`ifdef WBARB_PENDING_EN
  ,
  output logic [2**COUNTP-1:0] pending_o
`endif
);

  localparam logic GNT_ALU = 1'b0;
  localparam logic GNT_MEM = 1'b1;

  logic [COUNTP-1:0] fifo_addr_q [2];
  logic [WIDTH-1:0]  fifo_data_q [2];
  logic [1:0]        fifo_en_q   [2];

  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              last_grant_q, last_grant_d;
  logic [COUNTP-1:0] write_addr_q, write_addr_d;
  logic [WIDTH-1:0]  write_data_q, write_data_d;
  logic [1:0]        write_en_q, write_en_d;
  logic [WIDTH-1:0]  sp_data_q, sp_data_d;
  logic [1:0]        sp_en_q, sp_en_d;

  logic w_alu_elig, w_mem_elig, w_grant_alu, w_grant_mem, w_push;

  // SP collisions are resolved by stalling the general write, never the SP path.
  assign w_alu_elig  = !rst_i && !flush_i && alu_valid &&
                       !(alu_addr == SPREG && sp_valid);
  assign w_mem_elig  = !rst_i && !flush_i && (count_q != 2'd0) &&
                       !(fifo_addr_q[rd_ptr_q] == SPREG && sp_valid);
  assign w_grant_alu = w_alu_elig && (!w_mem_elig || last_grant_q == GNT_MEM);
  assign w_grant_mem = w_mem_elig && !w_grant_alu;

  assign alu_ready   = w_grant_alu;
  assign mem_ready   = !rst_i && !flush_i && (count_q != 2'd2);
  assign w_push      = mem_valid && mem_ready;

  always_comb begin
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    last_grant_d = last_grant_q;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    write_en_d   = 2'd0;
    if (flush_i) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (w_push)      wr_ptr_d = ~wr_ptr_q;
      if (w_grant_mem) rd_ptr_d = ~rd_ptr_q;
      case ({w_push, w_grant_mem})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
    if (w_grant_alu) begin
      last_grant_d = GNT_ALU;
      write_addr_d = alu_addr;
      write_data_d = alu_data;
      write_en_d   = alu_en;
    end else if (w_grant_mem) begin
      last_grant_d = GNT_MEM;
      write_addr_d = fifo_addr_q[rd_ptr_q];
      write_data_d = fifo_data_q[rd_ptr_q];
      write_en_d   = fifo_en_q[rd_ptr_q];
    end
    sp_en_d   = sp_valid ? sp_en_i : 2'd0;
    sp_data_d = sp_valid ? sp_data_i : sp_data_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q      <= 2'd0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      last_grant_q <= GNT_MEM;
      write_addr_q <= '0;
      write_data_q <= '0;
      write_en_q   <= 2'd0;
      sp_data_q    <= '0;
      sp_en_q      <= 2'd0;
    end else begin
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      last_grant_q <= last_grant_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      write_en_q   <= write_en_d;
      sp_data_q    <= sp_data_d;
      sp_en_q      <= sp_en_d;
    end
  end

  // Entry storage needs no reset: validity is tracked entirely by count_q.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      fifo_addr_q[wr_ptr_q] <= mem_addr;
      fifo_data_q[wr_ptr_q] <= mem_data;
      fifo_en_q[wr_ptr_q]   <= mem_en;
    end
  end

  assign write_addr = write_addr_q;
  assign write_data = write_data_q;
  assign write_en   = write_en_q;
  assign sp_data_o  = sp_data_q;
  assign sp_en      = sp_en_q;

`ifdef WBARB_PENDING_EN
  logic [1:0] w_entry_vld;

  assign w_entry_vld[0] = (count_q == 2'd2) || (count_q == 2'd1 && rd_ptr_q == 1'b0);
  assign w_entry_vld[1] = (count_q == 2'd2) || (count_q == 2'd1 && rd_ptr_q == 1'b1);

  for (genvar r = 0; r < 2**COUNTP; r++) begin : g_pending
    assign pending_o[r] =
        (write_en_q != 2'd0 && write_addr_q == COUNTP'(r)) ||
        (w_entry_vld[0] && fifo_en_q[0] != 2'd0 && fifo_addr_q[0] == COUNTP'(r)) ||
        (w_entry_vld[1] && fifo_en_q[1] != 2'd0 && fifo_addr_q[1] == COUNTP'(r));
  end
`endif

endmodule

`default_nettype wire
